// File: rtl/can_rx_fifo.sv
// can_rx_fifo: receive frame buffer behind the CAN controller.
// Good frames that pass the mask/match acceptance filter are queued in a
// small FIFO. The CPU reads the head entry through a register window and
// pops it explicitly by writing STATUS. irq is raised while frames are queued
// and the interrupt is enabled.
module can_rx_fifo #(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frm_valid,
   input  logic [28:0] frm_id,
   input  logic        frm_ext,
   input  logic        frm_rtr,
   input  logic [3:0]  frm_dlc,
   input  logic [63:0] frm_data,
   input  logic        cs,
   input  logic [2:0]  rs,
   input  logic [3:0]  bytesel,
   input  logic [31:0] d,
   output logic [31:0] q,
   output logic        irq
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;

   typedef struct packed {
      logic [28:0] id;
      logic        ext;
      logic        rtr;
      logic [3:0]  dlc;
      logic [63:0] data;
   } frame_t;

   // frame storage; the pointers give it meaning, so it is never reset
   frame_t mem_q [DEPTH];

   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  irqen_q, irqen_d;
   logic [28:0]           match_id_q, match_id_d;
   logic                  match_ext_q, match_ext_d;
   logic [28:0]           mask_id_q, mask_id_d;
   logic                  mask_ext_q, mask_ext_d;

   logic   wr_en, full, empty;
   logic   pop_req, pop_eff, ovf_clr;
   logic   accept, push, ovf_evt;
   frame_t frm_in, head;

   // only d[30:29] have no register bit behind them
   logic unused_d;
   assign unused_d = ^d[30:29];

   // bus decode, acceptance filter and push/pop qualification
   always_comb begin
      wr_en   = cs & (bytesel != 4'b0000);
      full    = (count_q == CW'(DEPTH));
      empty   = (count_q == '0);
      pop_req = wr_en & (rs == 3'd1) & bytesel[1] & d[8];
      ovf_clr = wr_en & (rs == 3'd1) & bytesel[1] & d[14];
      pop_eff = pop_req & ~empty;
      accept  = (((frm_id ^ match_id_q) & mask_id_q) == 29'd0) &
                (~mask_ext_q | (frm_ext == match_ext_q));
      // a pop in the same cycle frees the slot, so a full FIFO can still take the frame
      push    = frm_valid & accept & (~full | pop_eff);
      ovf_evt = frm_valid & accept & full & ~pop_eff;
      frm_in  = '{id: frm_id, ext: frm_ext, rtr: frm_rtr, dlc: frm_dlc, data: frm_data};
   end

   // next-state for pointers, count, flags and filter registers
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      ovf_d       = ovf_q;
      irqen_d     = irqen_q;
      match_id_d  = match_id_q;
      match_ext_d = match_ext_q;
      mask_id_d   = mask_id_q;
      mask_ext_d  = mask_ext_q;

      if (push)    wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_eff) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop_eff})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // a drop in the same cycle as a clear must stay visible, so set is last
      if (ovf_clr) ovf_d = 1'b0;
      if (ovf_evt) ovf_d = 1'b1;

      if (wr_en && rs == 3'd1 && bytesel[2]) irqen_d = d[16];

      // filter registers only take full-word writes
      if (wr_en && bytesel == 4'b1111) begin
         if (rs == 3'd4) begin
            match_ext_d = d[31];
            match_id_d  = d[28:0];
         end
         if (rs == 3'd5) begin
            mask_ext_d = d[31];
            mask_id_d  = d[28:0];
         end
      end
   end

   // control state registers, synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         irqen_q     <= 1'b0;
         match_id_q  <= '0;
         match_ext_q <= 1'b0;
         mask_id_q   <= '0;
         mask_ext_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         irqen_q     <= irqen_d;
         match_id_q  <= match_id_d;
         match_ext_q <= match_ext_d;
         mask_id_q   <= mask_id_d;
         mask_ext_q  <= mask_ext_d;
      end
   end

   // frame storage write; a frame arriving during reset is dropped
   always_ff @(posedge clk) begin
      if (push && !reset) mem_q[wr_ptr_q] <= frm_in;
   end

   // register read window; head fields read as zero while empty
   always_comb begin
      head = empty ? '0 : mem_q[rd_ptr_q];
      q    = 32'd0;
      if (cs) begin
         case (rs)
            3'd0: q = {head.ext, head.rtr, 1'b0, head.id};
            3'd1: begin
               q[3:0]     = head.dlc;
               q[8 +: CW] = count_q;
               q[12]      = empty;
               q[13]      = full;
               q[14]      = ovf_q;
               q[16]      = irqen_q;
            end
            3'd2: q = head.data[31:0];
            3'd3: q = head.data[63:32];
            3'd4: q = {match_ext_q, 2'b00, match_id_q};
            3'd5: q = {mask_ext_q, 2'b00, mask_id_q};
            default: q = 32'd0;
         endcase
      end
   end

   // interrupt straight from registered state
   always_comb begin
      irq = irqen_q & ~empty;
   end

endmodule
